// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
//   Time-multiplexed scanner for a 4-digit 7-segment display. Each digit is
//   given a slot of CLK_DIV cycles. The first BLANK_CYCLES cycles of a slot
//   keep all digit enables off so the previous digit cannot ghost. A new
//   value can be loaded at any time, but it only becomes visible at the next
//   frame boundary, so a frame never mixes old and new digits.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   value_in   : four BCD nibbles, [3:0] is digit 0 (least significant)
//   load       : capture value_in this cycle
//   blank_lz   : enable leading-zero blanking (registered, effective next cycle)
//   digit_code : nibble for the 7-segment decoder, 4'hF = blank
//   digit_sel  : one-hot, active-high digit enable
//   frame_done : one-cycle pulse on the last cycle of each four-slot frame
// ---------------------------------------------------------------------------
module display_scanner #(
  parameter int CLK_DIV      = 12000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit_code,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      pending_q, pending_d;
  logic [15:0]      active_q, active_d;
  logic             blz_q, blz_d;
  // Registered copy of reset: lets the outputs show the reset pattern without
  // a combinational path from rst, and holds the counter at zero for the
  // first cycle after release so counting restarts cleanly at cnt=0.
  logic             in_rst_q;

  logic             last_cyc;
  logic             boundary;
  logic             dead_time;
  logic             lz_blank;
  logic [3:0]       nibble;

  // Digit i (i > 0) is a leading zero when it and every digit above it are 0.
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] i);
    logic z;
    case (i)
      2'd3:    z = (v[15:12] == 4'h0);
      2'd2:    z = (v[15:8]  == 8'h00);
      2'd1:    z = (v[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  always_comb begin
    last_cyc  = (cnt_q == CNT_MAX);
    boundary  = last_cyc && (idx_q == 2'd3) && !in_rst_q;

    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = load ? value_in : pending_q;
    active_d  = active_q;
    blz_d     = blank_lz;

    if (!in_rst_q) begin
      if (last_cyc) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A load landing exactly on the boundary bypasses pending.
    if (boundary) begin
      active_d = load ? value_in : pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pending_q <= 16'h0000;
      active_q  <= 16'h0000;
      blz_q     <= 1'b0;
      in_rst_q  <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      blz_q     <= blz_d;
      in_rst_q  <= 1'b0;
    end
  end

  always_comb begin
    nibble     = active_q[{idx_q, 2'b00} +: 4];
    lz_blank   = blz_q && lead_zero(active_q, idx_q);
    dead_time  = (BLANK_CYCLES != 0) && (cnt_q < BLANK_C);

    frame_done = boundary;
    digit_code = (in_rst_q || lz_blank) ? 4'hF : nibble;
    digit_sel  = (in_rst_q || dead_time) ? 4'b0000 : (4'b0001 << idx_q);
  end

endmodule

// File: tb/tb_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_display_scanner
//   Directed bench for display_scanner with CLK_DIV=4, BLANK_CYCLES=1.
//   The stimulus process applies inputs once per cycle and queues the outputs
//   expected during that same cycle; a monitor process pops and compares on
//   every falling edge.
// ---------------------------------------------------------------------------
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit_code;
  logic [3:0]  digit_sel;
  logic        frame_done;

  display_scanner #(
    .CLK_DIV      (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit_code (digit_code),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] tag;
    logic [3:0]  sel;
    logic [3:0]  code;
    logic        fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   tag_ctr = 0;

  // Monitor: one comparison per queued cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (digit_sel !== e.sel || digit_code !== e.code || frame_done !== e.fd) begin
          n_fail++;
          $display("FAIL cyc%0d: got sel=%b code=%h fd=%b, want sel=%b code=%h fd=%b",
                   e.tag, digit_sel, digit_code, frame_done, e.sel, e.code, e.fd);
        end
      end
    end
  end

  // Apply inputs for one cycle and queue the outputs expected in that cycle.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic bz, input logic [3:0] es, input logic [3:0] ec,
                      input logic ef);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag  = 16'(tag_ctr);
    e.sel  = es;
    e.code = ec;
    e.fd   = ef;
    sb_q.push_back(e);
    tag_ctr++;
    rst      = r;
    load     = ld;
    value_in = v;
    blank_lz = bz;
  endtask

  // One frame (or its first ncyc cycles). codes holds the hand-computed code
  // shown for digit 3..0; up to two loads at cycles la/lb (-1 = none).
  task automatic frame(input logic [15:0] codes, input logic bz, input int ncyc,
                       input int la, input logic [15:0] lva,
                       input int lb, input logic [15:0] lvb);
    int         slot;
    logic [3:0] es;
    logic       ld;
    logic [15:0] v;
    for (int k = 0; k < ncyc; k++) begin
      slot = k / 4;
      es   = ((k % 4) == 0) ? 4'b0000 : (4'b0001 << slot);
      ld   = (k == la) || (k == lb);
      v    = (k == la) ? lva : ((k == lb) ? lvb : 16'hEEEE);
      step(1'b0, ld, v, bz, es, codes[4*slot +: 4], (k == 15));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value_in = 16'hEEEE; blank_lz = 1'b0;
    repeat (2) @(posedge clk);

    // Reset: outputs held at the reset pattern, a load during reset is dropped.
    step(1'b1, 1'b0, 16'hEEEE, 1'b0, 4'b0000, 4'hF, 1'b0);
    step(1'b1, 1'b1, 16'h7777, 1'b0, 4'b0000, 4'hF, 1'b0);
    step(1'b1, 1'b0, 16'hEEEE, 1'b0, 4'b0000, 4'hF, 1'b0);
    step(1'b0, 1'b0, 16'hEEEE, 1'b0, 4'b0000, 4'hF, 1'b0);

    // Frame 1: still all zero, 1234 loaded mid-frame.
    frame(16'h0000, 1'b0, 16, 6, 16'h1234, -1, 16'h0);
    // Frame 2: shows 1234; load 0050; enable blanking ahead of frame 3.
    frame(16'h1234, 1'b1, 16, 10, 16'h0050, -1, 16'h0);
    // Frame 3: 0050 with blanking -> F,F,5,0 (digit 3..0).
    frame(16'hFF50, 1'b1, 16, -1, 16'h0, -1, 16'h0);
    // Frame 4: 0050 without blanking; load 0000.
    frame(16'h0050, 1'b0, 16, 7, 16'h0000, -1, 16'h0);
    // Frame 5: 0000 with blanking -> F,F,F,0; 1234 then ABCD on the boundary.
    frame(16'hFFF0, 1'b1, 16, 3, 16'h1234, 15, 16'hABCD);
    // Frame 6: boundary bypass shows ABCD; two loads, last wins.
    frame(16'hABCD, 1'b0, 16, 2, 16'h1111, 9, 16'h2222);
    // Frame 7: 2222; load 9876.
    frame(16'h2222, 1'b0, 16, 5, 16'h9876, -1, 16'h0);
    // Frame 8: 9876 until slot 2, then a one-cycle reset with a dropped load.
    frame(16'h9876, 1'b0, 9, -1, 16'h0, -1, 16'h0);
    step(1'b1, 1'b1, 16'h5555, 1'b0, 4'b0100, 4'h8, 1'b0);
    step(1'b0, 1'b0, 16'hEEEE, 1'b0, 4'b0000, 4'hF, 1'b0);
    // Counting restarts; frame_done only 16 cycles after release.
    frame(16'h0000, 1'b0, 16, -1, 16'h0, -1, 16'h0);
    frame(16'h0000, 1'b0, 16, -1, 16'h0, -1, 16'h0);

    @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter CLK_DIV, default 12000: clock cycles per digit slot; legal range 2 to 2^20.
REQ-002 Parameter BLANK_CYCLES, default 500: anti-ghost dead time at the start of each slot; legal range 0 to CLK_DIV-1.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port value_in  input  16  four BCD nibbles; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 Port load  input  1  when high, value_in is captured this cycle.
REQ-007 Port blank_lz  input  1  when high, leading-zero blanking is enabled.
REQ-008 Port digit_code  output  4  nibble for the downstream 7-segment decoder; 4'hF means blank.
REQ-009 Port digit_sel  output  4  one-hot, active-high digit enable; bit i enables digit i.
REQ-010 Port frame_done  output  1  one-cycle pulse on the last cycle of each four-slot frame.

Function
REQ-011 The block SHALL hold the following internal registers: cnt (slot cycle counter, 0..CLK_DIV-1), idx (slot index, 0..3), pending (16 bits), active (16 bits).
REQ-012 All outputs SHALL decode only registered state; there SHALL be no combinational path from any input to any output.
REQ-013 Counting: if cnt < CLK_DIV-1, cnt SHALL increment; otherwise cnt SHALL go to 0 and idx SHALL advance modulo 4 (3 wraps to 0).
REQ-014 The frame boundary SHALL be the cycle in which cnt == CLK_DIV-1 and idx == 3; frame_done SHALL be high in exactly that cycle.
REQ-015 Load: when load is high, pending SHALL be set to value_in; if several loads occur within one frame, the last one wins.
REQ-016 Commit: at the frame boundary, active SHALL be set to value_in if load is high in that cycle (bypass), otherwise to pending.
REQ-017 The active value SHALL never change mid-frame, so that no tearing is visible.
REQ-018 digit_sel SHALL be 4'b0000 while cnt < BLANK_CYCLES; otherwise it SHALL be one-hot at bit idx.
REQ-019 digit_code SHALL equal the nibble active[4*idx+3 : 4*idx], except where leading-zero blanking replaces it (REQ-020).
REQ-020 When blank_lz is high, digit i (for i = 3, 2, 1) SHALL output 4'hF if its nibble and the nibbles of every digit above it are all zero; digit 0 SHALL never be blanked.
REQ-021 blank_lz SHALL be a registered input, sampled every cycle and effective from the next cycle.
REQ-022 Non-BCD nibbles (4'hA to 4'hE) SHALL pass through unmodified; blanking them is the decoder's job.
REQ-023 When BLANK_CYCLES == 0, digit_sel SHALL never be all-zero outside reset.

Reset
REQ-024 While rst is high, the block SHALL set cnt=0, idx=0, pending=16'h0000, active=16'h0000 and blank_lz register=0.
REQ-025 While rst is high, the outputs SHALL be digit_sel=4'b0000, digit_code=4'hF and frame_done=0.
REQ-026 During reset, load SHALL be ignored.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no commit and no frame_done.
REQ-028 Counting SHALL resume from cnt=0, idx=0 on the first cycle after rst deasserts.

Verification
REQ-029 The bench SHALL run with CLK_DIV=4 and BLANK_CYCLES=1 and SHALL cover the following directed scenarios:
- Reset for 3 cycles -> digit_sel=0000, digit_code=F, frame_done=0; after release, 1 cycle of digit_sel=0000, then 3 cycles of digit_sel=0001 with digit_code=0.
- load 16'h1234 for one cycle mid-frame -> the current frame still shows 0,0,0,0; the next frame shows codes 4,3,2,1 with digit_sel 0001,0010,0100,1000; frame_done pulses once every 16 cycles.
- Active value 16'h0050 -> blank_lz=1 gives codes 0,5,F,F; blank_lz=0 gives 0,5,0,0. Active value 16'h0000 with blank_lz=1 gives 0,F,F,F.
- pending=16'h1234, then load 16'hABCD exactly in the frame-boundary cycle -> the next frame shows D,C,B,A.
- Loads of 16'h1111 then 16'h2222 within one frame -> the next frame shows 2,2,2,2.
- rst pulsed for 1 cycle at idx=2 with active=16'h9876 -> digit_code=F during rst, then digit 0 shows 0; no frame_done until 16 cycles after release.
